// File: rtl/modinv_pkg.sv
// Shared types and defaults for the modular-inverse scheduler.
package modinv_pkg;

    localparam int DEFAULT_DATA_WIDTH = 1024;
    localparam int DEFAULT_NREQ       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/modinv_sched_arb.sv
// Combinational round-robin arbiter: searches last+1, last+2, ... mod NREQ
// and returns the first requester found as a one-hot grant plus its index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    int idx;

    // Walk the requesters starting just after the previous winner.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(last) + off) % NREQ;
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = IDW'(idx);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/modinv_sched.sv
// Shares one ModInvert engine among NREQ requesters. One operation is in
// flight at a time; a zero modulus is answered locally with an error flag.
module modinv_sched
    import modinv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NREQ       = DEFAULT_NREQ,
    parameter int IDW        = $clog2(NREQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DATA_WIDTH-1:0] req_bits_base,
    input  logic [NREQ*DATA_WIDTH-1:0] req_bits_mod,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_bits_res,
    output logic                     rsp_err,
    output logic                     eng_din_valid,
    input  logic                     eng_din_ready,
    output logic [DATA_WIDTH-1:0]    eng_din_bits_base,
    output logic [DATA_WIDTH-1:0]    eng_din_bits_mod,
    input  logic                     eng_dout_valid,
    output logic                     eng_dout_ready,
    input  logic [DATA_WIDTH-1:0]    eng_dout_bits_res,
    output logic                     busy,
    output logic [IDW-1:0]           owner
);

    state_t                state;
    logic [IDW-1:0]        last;
    logic [DATA_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] mod_q;

    logic [NREQ-1:0]       gnt;
    logic [IDW-1:0]        gnt_id;
    logic                  any;
    logic [DATA_WIDTH-1:0] sel_base;
    logic [DATA_WIDTH-1:0] sel_mod;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req_valid),
        .last   (last),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any)
    );

    // Pick the operand slices belonging to the requester that would win now.
    always_comb begin
        sel_base = '0;
        sel_mod  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                sel_base = req_bits_base[i*DATA_WIDTH +: DATA_WIDTH];
                sel_mod  = req_bits_mod[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Handshake strobes decode straight from the registered state so they
    // are stable for the whole cycle; req_ready is the only same-cycle path.
    always_comb begin
        req_ready = (state == IDLE) ? gnt : '0;
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    assign eng_din_valid     = (state == ISSUE);
    assign eng_dout_ready    = (state == WAIT);
    assign eng_din_bits_base = base_q;
    assign eng_din_bits_mod  = mod_q;
    assign busy              = (state != IDLE);

    // Main sequencer: accept, issue to engine, collect result, hand back.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            last         <= IDW'(NREQ - 1);
            owner        <= '0;
            base_q       <= '0;
            mod_q        <= '0;
            rsp_bits_res <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        base_q <= sel_base;
                        mod_q  <= sel_mod;
                        owner  <= gnt_id;
                        last   <= gnt_id;
                        if (sel_mod == '0) begin
                            rsp_bits_res <= '0;
                            rsp_err      <= 1'b1;
                            state        <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (eng_din_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (eng_dout_valid) begin
                        rsp_bits_res <= eng_dout_bits_res;
                        rsp_err      <= 1'b0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modinv_sched.sv
// Directed bench for modinv_sched with a small behavioural engine model.
module tb_modinv_sched;

    localparam int DW  = 16;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_bits_base = '0;
    logic [N*DW-1:0]   req_bits_mod = '0;
    logic [N-1:0]      rsp_valid;
    logic [N-1:0]      rsp_ready = '0;
    logic [DW-1:0]     rsp_bits_res;
    logic              rsp_err;
    logic              eng_din_valid;
    logic              eng_din_ready;
    logic [DW-1:0]     eng_din_bits_base;
    logic [DW-1:0]     eng_din_bits_mod;
    logic              eng_dout_valid;
    logic              eng_dout_ready;
    logic [DW-1:0]     eng_dout_bits_res;
    logic              busy;
    logic [IDW-1:0]    owner;

    int checks = 0;
    int errors = 0;

    // engine model state
    logic          e_busy;
    int            e_cnt;
    int            stall_cnt;
    int            stall_req = 0;
    int            din_seen = 0;
    logic [DW-1:0] e_base;
    logic [DW-1:0] e_mod;

    modinv_sched #(
        .DATA_WIDTH (DW),
        .NREQ       (N)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_bits_base     (req_bits_base),
        .req_bits_mod      (req_bits_mod),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_bits_res      (rsp_bits_res),
        .rsp_err           (rsp_err),
        .eng_din_valid     (eng_din_valid),
        .eng_din_ready     (eng_din_ready),
        .eng_din_bits_base (eng_din_bits_base),
        .eng_din_bits_mod  (eng_din_bits_mod),
        .eng_dout_valid    (eng_dout_valid),
        .eng_dout_ready    (eng_dout_ready),
        .eng_dout_bits_res (eng_dout_bits_res),
        .busy              (busy),
        .owner             (owner)
    );

    always #5 clock = ~clock;

    // Brute-force inverse used only by the engine model.
    function automatic logic [DW-1:0] modinv(input logic [DW-1:0] b, input logic [DW-1:0] m);
        int bb;
        int mm;
        bb = int'(b);
        mm = int'(m);
        for (int x = 1; x < mm; x++) begin
            if (((bb * x) % mm) == 1) return DW'(x);
        end
        return '0;
    endfunction

    // Engine model: raises din_ready after an optional stall, then answers
    // a few cycles after the transfer and holds dout until it is taken.
    always @(posedge clock) begin
        if (eng_din_valid) din_seen <= din_seen + 1;
        if (reset) begin
            eng_din_ready     <= 1'b0;
            eng_dout_valid    <= 1'b0;
            eng_dout_bits_res <= '0;
            e_busy            <= 1'b0;
            e_cnt             <= 0;
            stall_cnt         <= 0;
            e_base            <= '0;
            e_mod             <= '0;
        end else if (!e_busy) begin
            if (eng_din_valid && eng_din_ready) begin
                e_busy        <= 1'b1;
                eng_din_ready <= 1'b0;
                e_cnt         <= 3;
                e_base        <= eng_din_bits_base;
                e_mod         <= eng_din_bits_mod;
                stall_cnt     <= 0;
            end else if (eng_din_valid) begin
                if (stall_cnt < stall_req) stall_cnt <= stall_cnt + 1;
                else eng_din_ready <= 1'b1;
            end
        end else if (!eng_dout_valid) begin
            if (e_cnt > 0) e_cnt <= e_cnt - 1;
            else begin
                eng_dout_valid    <= 1'b1;
                eng_dout_bits_res <= modinv(e_base, e_mod);
            end
        end else if (eng_dout_ready) begin
            eng_dout_valid <= 1'b0;
            e_busy         <= 1'b0;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] b, input logic [DW-1:0] m);
        req_bits_base[i*DW +: DW] = b;
        req_bits_mod[i*DW +: DW]  = m;
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid == '0 && n < 100) begin
            step();
            n++;
        end
        check_output({tag, "_timeout"}, 64'(rsp_valid != '0), 64'd1);
    endtask

    task automatic wait_grant(input string tag);
        int n;
        n = 0;
        while (req_ready == '0 && n < 100) begin
            step();
            n++;
        end
        check_output({tag, "_timeout"}, 64'(req_ready != '0), 64'd1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        int seen_before;
        logic [N-1:0] oh;
        int rr_order[5] = '{0, 1, 2, 3, 0};
        int rr_res[5]   = '{5, 5, 4, 8, 5};

        $display("[TB] start");
        step();
        step();
        reset = 1'b0;
        #1;

        // reset state
        check_output("rst_busy",      64'(busy), 64'd0);
        check_output("rst_owner",     64'(owner), 64'd0);
        check_output("rst_req_ready", 64'(req_ready), 64'd0);
        check_output("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("rst_din_valid", 64'(eng_din_valid), 64'd0);
        check_output("rst_dout_rdy",  64'(eng_dout_ready), 64'd0);
        check_output("rst_err_res",   64'({rsp_err, rsp_bits_res}), 64'd0);

        // single request from requester 2: inv(3) mod 11 = 4
        set_req(2, 16'd3, 16'd11);
        req_valid = 4'b0100;
        #1;
        check_output("single_grant",  64'(req_ready), 64'b0100);
        check_output("single_din_pre", 64'(eng_din_valid), 64'd0);
        step();
        req_valid = '0;
        check_output("single_ready_pulse", 64'(req_ready), 64'd0);
        check_output("single_din_valid",   64'(eng_din_valid), 64'd1);
        check_output("single_din_ops",     64'({eng_din_bits_base, eng_din_bits_mod}), {32'd0, 16'd3, 16'd11});
        check_output("single_owner",       64'(owner), 64'd2);
        check_output("single_busy",        64'(busy), 64'd1);
        wait_rsp("single");
        check_output("single_rsp_valid", 64'(rsp_valid), 64'b0100);
        check_output("single_rsp",       64'({rsp_err, rsp_bits_res}), 64'd4);
        rsp_ready = 4'b0100;
        step();
        rsp_ready = '0;
        check_output("single_done", 64'({busy, rsp_valid}), 64'd0);

        // round robin from a fresh pointer, everyone valid
        pulse_reset();
        set_req(0, 16'd3, 16'd7);
        set_req(1, 16'd2, 16'd9);
        set_req(2, 16'd3, 16'd11);
        set_req(3, 16'd5, 16'd13);
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            oh = 4'(1 << rr_order[k]);
            wait_grant("rr");
            check_output("rr_grant", 64'(req_ready), 64'(oh));
            step();
            wait_rsp("rr");
            check_output("rr_rsp_valid", 64'(rsp_valid), 64'(oh));
            check_output("rr_rsp",       64'({rsp_err, rsp_bits_res}), 64'(rr_res[k]));
            check_output("rr_no_grant_in_resp", 64'(req_ready), 64'd0);
            rsp_ready = oh;
            step();
            rsp_ready = '0;
        end
        req_valid = '0;
        step();

        // zero modulus from requester 1
        seen_before = din_seen;
        set_req(1, 16'd5, 16'd0);
        req_valid = 4'b0010;
        #1;
        check_output("zm_grant", 64'(req_ready), 64'b0010);
        step();
        req_valid = '0;
        check_output("zm_rsp_valid", 64'(rsp_valid), 64'b0010);
        check_output("zm_rsp",       64'({rsp_err, rsp_bits_res}), 64'h10000);
        check_output("zm_no_din",    64'(eng_din_valid), 64'd0);
        step();
        step();
        check_output("zm_engine_untouched", 64'(din_seen - seen_before), 64'd0);
        rsp_ready = 4'b0010;
        step();
        rsp_ready = '0;

        // engine stalls din_ready for 5 cycles; operand changes are ignored
        stall_req = 5;
        set_req(3, 16'd5, 16'd13);
        req_valid = 4'b1000;
        #1;
        check_output("bp_grant", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            check_output("bp_din_hold", 64'({eng_din_valid, eng_din_bits_base, eng_din_bits_mod}), {31'd0, 1'b1, 16'd5, 16'd13});
            if (k < 5) check_output("bp_din_stall", 64'(eng_din_ready), 64'd0);
            if (k == 1) set_req(3, 16'hFFFF, 16'hFFFF);
            step();
        end
        stall_req = 0;
        wait_rsp("bp");

        // requester withholds rsp_ready for 7 cycles while another waits
        set_req(0, 16'd3, 16'd7);
        req_valid = 4'b0001;
        for (int k = 0; k < 7; k++) begin
            check_output("rbp_rsp_valid", 64'(rsp_valid), 64'b1000);
            check_output("rbp_rsp",       64'({rsp_err, rsp_bits_res}), 64'd8);
            check_output("rbp_no_grant",  64'(req_ready), 64'd0);
            step();
        end
        rsp_ready = 4'b1000;
        step();
        rsp_ready = '0;
        check_output("rbp_next_grant", 64'(req_ready), 64'b0001);
        req_valid = '0;
        #1;
        check_output("drop_no_grant", 64'(req_ready), 64'd0);
        step();
        check_output("drop_idle", 64'(busy), 64'd0);

        // reset while waiting on the engine
        set_req(2, 16'd3, 16'd11);
        set_req(3, 16'd5, 16'd13);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        begin
            int n;
            n = 0;
            while (!eng_dout_ready && n < 100) begin
                step();
                n++;
            end
            check_output("mid_wait_reached", 64'(eng_dout_ready), 64'd1);
        end
        pulse_reset();
        check_output("mr_busy",      64'(busy), 64'd0);
        check_output("mr_owner",     64'(owner), 64'd0);
        check_output("mr_valids",    64'({req_ready, rsp_valid}), 64'd0);
        check_output("mr_eng",       64'({eng_din_valid, eng_dout_ready}), 64'd0);
        check_output("mr_err_res",   64'({rsp_err, rsp_bits_res}), 64'd0);
        req_valid = 4'b1001;
        #1;
        check_output("mr_first_grant", 64'(req_ready), 64'b0001);
        step();
        req_valid = 4'b1000;
        wait_rsp("mr0");
        check_output("mr0_rsp", 64'({rsp_valid, rsp_err, rsp_bits_res}), {4'b0001, 1'b0, 16'd5});
        rsp_ready = 4'b0001;
        step();
        rsp_ready = '0;
        check_output("mr_second_grant", 64'(req_ready), 64'b1000);
        step();
        req_valid = '0;
        wait_rsp("mr3");
        check_output("mr3_rsp", 64'({rsp_valid, rsp_err, rsp_bits_res}), {4'b1000, 1'b0, 16'd8});
        rsp_ready = 4'b1000;
        step();
        rsp_ready = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modinv_sched.md
# modinv_sched

Round-robin scheduler that shares one `ModInvert` engine (iterative modular inverse, `DATA_WIDTH`-bit base/mod in, result out) among `NREQ` requesters. It accepts one request at a time and latches its operands. It drives the engine's din/dout valid/ready handshake and routes the result back to the owning requester. It sits between the key-setup clients (private-exponent and CRT-coefficient generators) and the single `ModInvert` instance.

## Interface
Parameters:
- `DATA_WIDTH`, 1024: operand/result width.
- `NREQ`, 4: number of requesters (2..16).
- `IDW`, `$clog2(NREQ)`: owner-id width (derived).

Ports:
- `clock`  in  1: sole clock. All logic is rising-edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  NREQ: per-requester request valid.
- `req_ready`  out  NREQ: per-requester accept, at most one bit high.
- `req_bits_base`  in  NREQ*DATA_WIDTH: base, slice i belongs to requester i.
- `req_bits_mod`  in  NREQ*DATA_WIDTH: modulus, slice i belongs to requester i.
- `rsp_valid`  out  NREQ: per-requester response valid, at most one bit high.
- `rsp_ready`  in  NREQ: per-requester response accept.
- `rsp_bits_res`  out  DATA_WIDTH: result, shared by all requesters, valid with `rsp_valid`.
- `rsp_err`  out  1: high with `rsp_valid` when the modulus was zero.
- `eng_din_valid`  out  1: engine input valid.
- `eng_din_ready`  in  1: engine input ready.
- `eng_din_bits_base`  out  DATA_WIDTH: engine base.
- `eng_din_bits_mod`  out  DATA_WIDTH: engine modulus.
- `eng_dout_valid`  in  1: engine result valid.
- `eng_dout_ready`  out  1: engine result ready.
- `eng_dout_bits_res`  in  DATA_WIDTH: engine result.
- `busy`  out  1: high in any state other than IDLE.
- `owner`  out  IDW: id of the current or last granted requester.

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - The grant is computed combinationally from `req_valid` and the pointer `last`. Search order is `last+1, last+2, …` mod NREQ.
  - If any `req_valid` bit is high, drive `req_ready[g]` high for that cycle only.
  - On that edge: latch the base and mod slices for `g`, set `owner=g` and `last=g`.
  - Next state: RESP if the latched mod is 0, with `rsp_bits_res=0` and `rsp_err=1`, and the engine is not touched. Otherwise ISSUE.
- **ISSUE**
  - Hold `eng_din_valid=1` with the latched operands until the edge where `eng_din_ready=1`, then go to WAIT.
- **WAIT**
  - Hold `eng_dout_ready=1`.
  - On the edge where `eng_dout_valid=1`, register `eng_dout_bits_res` into `rsp_bits_res`, clear `rsp_err`, and go to RESP.
- **RESP**
  - Hold `rsp_valid[owner]=1`, with `rsp_bits_res` and `rsp_err` stable.
  - On the edge where `rsp_ready[owner]=1`, go to IDLE.
- The block never inspects the operand value except for the zero-modulus test.
- Only one operation is in flight at a time.

## Timing
- **Reset values:** state IDLE, `last=NREQ-1` (requester 0 has first priority), `owner=0`, all `req_ready`/`rsp_valid` low, `rsp_err=0`, `rsp_bits_res=0`, `eng_din_valid=0`, `eng_dout_ready=0`, `busy=0`, operand registers 0.
- **Reset mid-operation:** the operation is abandoned with no response. The engine shares `reset`.
- **Latency:**
  - Accept (cycle 0) to `eng_din_valid` high: 1 cycle.
  - Engine `dout_valid` edge to `rsp_valid`: 1 cycle.
  - Zero-mod accept to `rsp_valid`: 1 cycle.
  - Response accept to next grant: 1 cycle, since IDLE is re-entered.
- **Handshakes:**
  - A request transfers on the edge where `req_valid[i] & req_ready[i]`.
  - A requester may drop `req_valid` before it is granted. No state changes in that case.
  - Operands are sampled only on the accept edge. Later changes to `req_bits_*` are ignored.
- **Simultaneous events:**
  - All requesters valid: grants rotate 0,1,2,3,0,…
  - A requester re-asserting `req_valid` while in RESP is not granted until IDLE, and then only if it wins the round-robin.
- **Output hold:** `eng_din_*` stay stable while `eng_din_valid` is high. `rsp_*` stay stable while `rsp_valid` is high.

## Structure
- Package `modinv_pkg`: state enum (IDLE/ISSUE/WAIT/RESP) and the default `DATA_WIDTH` constant.
- Sub-module `rr_arbiter` (combinational, parameter `NREQ`):
  - Inputs: `req` and `last`.
  - Outputs: one-hot `gnt`, `gnt_id`, and `any`.
  - `modinv_sched` owns the `last` register.
- Operand and result registers: 3 × `DATA_WIDTH` flops in `modinv_sched`.

## Test plan
- **Single request:** requester 2 requests base=0x3, mod=0xB, with a behavioural engine model.
  - `req_ready[2]` pulses once.
  - `eng_din_valid` rises 1 cycle later.
  - `rsp_valid[2]` returns with res=0x4 and `rsp_err=0`.
- **Round-robin:** all 4 requesters held valid continuously.
  - Grant order is 0,1,2,3,0.
  - Each `rsp_valid` goes only to its owner with the correct result.
- **Zero modulus:** requester 1 sends mod=0.
  - The engine never sees `eng_din_valid`.
  - `rsp_valid[1]` is high 1 cycle after accept, with res=0 and `rsp_err=1`.
- **Backpressure:**
  - Engine holds `din_ready` low 5 cycles: `eng_din_*` stay stable throughout.
  - Requester withholds `rsp_ready` for 7 cycles: `rsp_*` stay stable and no new grant is issued.
- **Reset mid-WAIT:** assert `reset` for 1 cycle.
  - All outputs return to reset values.
  - The next request from requester 0 is granted first.
- **RSA-size pass:** 1024-bit private_key_ld/public_key_n vector pairs from file, through the real `ModInvert`.
  - Results match the golden output file.
